// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: one single-port SRAM shared by fetch and data ports.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUS_WIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [BUS_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  hold_if,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [BUS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_valid,
  output logic                  hold_mem,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [BUS_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP_IF = 2'd1,
    ST_RESP_LD = 2'd2,
    ST_RESP_ST = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       w_grant_if, w_grant_mem, w_starved;

  // A zero limit disables the fairness override entirely.
  assign w_starved = (c_starve_limit != 4'd0) && (starve_cnt_q == c_starve_limit);

  always_comb begin
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    if (!rst) begin
      if (if_req && mem_req) begin
        w_grant_if  = w_starved;
        w_grant_mem = ~w_starved;
      end else begin
        w_grant_if  = if_req;
        w_grant_mem = mem_req;
      end
    end
  end

  assign hold_if    = if_req & ~w_grant_if;
  assign hold_mem   = mem_req & ~w_grant_mem;
  assign sram_en    = w_grant_if | w_grant_mem;
  assign sram_we    = w_grant_mem & mem_we;
  assign sram_addr  = w_grant_mem ? mem_addr : (w_grant_if ? if_addr : '0);
  assign sram_wdata = (w_grant_mem & mem_we) ? mem_wdata : '0;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || w_grant_if) begin
      starve_cnt_d = 4'd0;
    end else if (hold_if && (starve_cnt_q < c_starve_limit)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d   = ST_IDLE;
    if_valid  = 1'b0;
    if_rdata  = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    if (w_grant_if) begin
      state_d = ST_RESP_IF;
    end else if (w_grant_mem) begin
      state_d = mem_we ? ST_RESP_ST : ST_RESP_LD;
    end
    case (state_q)
      ST_RESP_IF: begin
        if_valid = 1'b1;
        if_rdata = sram_rdata;
      end
      ST_RESP_LD: begin
        mem_valid = 1'b1;
        mem_rdata = sram_rdata;
      end
      ST_RESP_ST: mem_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire
